bit_serial_fifo: RTL and testbench
==================================

BIT_SERIAL_FIFO -- requirements
Module: bit_serial_fifo

Interface
REQ-001 Parameter DEPTH_BYTES, default 4096: storage capacity in bytes; SHALL be a power of two, at most 4096.
REQ-002 Derived constant DEPTH_BITS = 8*DEPTH_BYTES: capacity in bits; maximum 32768, which fits dcount_out.
REQ-003 clk  input  1: single clock; all logic on its rising edge.
REQ-004 srst  input  1: reset, synchronous, active-low.
REQ-005 din  input  8: byte to write; bit 7 is first in stream order.
REQ-006 wr_en  input  1: write request for din in this cycle.
REQ-007 rd_en  input  1: request to pop one bit in this cycle.
REQ-008 dout  output  1: popped bit, registered.
REQ-009 d_valid_out  output  1: dout carries a popped bit this cycle.
REQ-010 dcount_out  output  16: current occupancy in bits, registered.

Function
REQ-011 Byte-write, bit-read FIFO; bits leave in write order, MSB of each byte first.
REQ-012 Storage: DEPTH_BYTES x 8 memory; byte write pointer wraps modulo DEPTH_BYTES; bit read pointer wraps modulo DEPTH_BITS.
REQ-013 Read-pointer decode: byte address = rd_ptr[MSBs:3]; bit selected = 7 - rd_ptr[2:0].
REQ-014 Write accepted iff wr_en=1 and pre-edge count <= DEPTH_BITS-8; byte stored at wr_ptr; wr_ptr += 1.
REQ-015 Write not accepted (fewer than 8 free bits): din dropped; no pointer or count change.
REQ-016 Read accepted iff rd_en=1 and pre-edge count >= 1; rd_ptr += 1.
REQ-017 Accepted read: at the same edge, dout <= selected bit and d_valid_out <= 1; latency is 1 cycle from rd_en.
REQ-018 No accepted read this edge: d_valid_out <= 0 and dout <= 0.
REQ-019 Read with count 0 is ignored, even when a write is accepted in the same cycle; no bypass.
REQ-020 Count update per edge: count_next = count + 8*(write accepted) - (read accepted).
REQ-021 Simultaneous accepted write and read: net count change +7.
REQ-022 dcount_out = count after the edge; no combinational path from inputs to any output.
REQ-023 Full/empty tests use only the pre-edge count; dcount_out never exceeds DEPTH_BITS and never underflows.
REQ-024 A read in the cycle after a write returns that write's bit 7 when the FIFO was empty; the memory read path sees the newly written byte.
REQ-025 Back-to-back reads sustain 1 bit/cycle; back-to-back writes sustain 1 byte/cycle.

Reset
REQ-026 srst=0 at a rising edge: wr_ptr=0, rd_ptr=0, count=0, dcount_out=0, dout=0, d_valid_out=0.
REQ-027 Reset SHALL override wr_en and rd_en in the same cycle.
REQ-028 Memory contents need not be cleared; data is unreachable after reset.
REQ-029 Reset mid-stream discards all buffered bits; the next written byte is read first.

Verification
REQ-030 Write 0xA5 alone -> dcount_out=8 next cycle; then 8 consecutive rd_en -> dout 1,0,1,0,0,1,0,1 with d_valid_out=1 each cycle; dcount_out ends at 0.
REQ-031 Empty FIFO with rd_en=1 -> d_valid_out=0, dout=0, dcount_out stays 0.
REQ-032 Count=8 (byte 0xFF), then wr_en=1 din=0x00 together with rd_en=1 -> dcount_out=15, dout=1; remaining bits read 1x7 then 0x8.
REQ-033 Write DEPTH_BYTES bytes -> dcount_out=DEPTH_BITS; one more write is dropped; then a 1-bit read followed by a write is still dropped (only 1 bit free); after 8 reads the next write is accepted.
REQ-034 Fill, read past wrap-around -> byte order preserved across the pointer wrap.
REQ-035 Write 3 bytes, read 5 bits, then srst=0 one cycle with wr_en=rd_en=1 -> all outputs 0; next write 0x80 and one read -> dout=1.

Source files
------------

// File: rtl/bit_serial_fifo.sv
// bit_serial_fifo: byte-wide write, bit-wide read FIFO.
// Bytes are stored whole; the read side walks a bit pointer, MSB of each byte first.
// dout, d_valid_out and dcount_out all come straight from registers.
module bit_serial_fifo #(
  parameter int DEPTH_BYTES = 4096  // power of two, 2..4096
) (
  input  logic        clk,
  input  logic        srst,
  input  logic [7:0]  din,
  input  logic        wr_en,
  input  logic        rd_en,
  output logic        dout,
  output logic        d_valid_out,
  output logic [15:0] dcount_out
);

  localparam int DEPTH_BITS = 8 * DEPTH_BYTES;
  localparam int AW         = $clog2(DEPTH_BYTES);
  // A write needs a whole byte of free space.
  localparam logic [15:0] WR_LIMIT = 16'(DEPTH_BITS - 8);

  logic [7:0]    mem [DEPTH_BYTES];
  logic [AW-1:0] wr_ptr;
  logic [AW+2:0] rd_ptr;
  logic [15:0]   count;
  logic          wr_ok;
  logic          rd_ok;
  logic [7:0]    rd_byte;
  logic          rd_bit;

  // Accept decisions use only the pre-edge count; the read port is asynchronous,
  // so a byte written at one edge is visible to a read at the next.
  always_comb begin
    wr_ok   = wr_en && (count <= WR_LIMIT);
    rd_ok   = rd_en && (count != 16'd0);
    rd_byte = mem[rd_ptr[AW+2:3]];
    rd_bit  = rd_byte[3'd7 - rd_ptr[2:0]];
  end

  // Storage array; contents are left alone on reset since the pointers make
  // stale data unreachable.
  always_ff @(posedge clk) begin
    if (srst && wr_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers, occupancy and the registered output bit.
  always_ff @(posedge clk) begin
    if (!srst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      dout        <= 1'b0;
      d_valid_out <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count       <= count + (wr_ok ? 16'd8 : 16'd0) - (rd_ok ? 16'd1 : 16'd0);
      dout        <= rd_ok ? rd_bit : 1'b0;
      d_valid_out <= rd_ok;
    end
  end

  assign dcount_out = count;

endmodule

// File: tb/tb_bit_serial_fifo.sv
// Testbench for bit_serial_fifo: directed steps plus random traffic, checked
// against a bit queue that models the FIFO's stream behaviour.
module tb_bit_serial_fifo;

  localparam int DBYTES = 16;
  localparam int DBITS  = 8 * DBYTES;

  logic        clk = 1'b0;
  logic        srst;
  logic [7:0]  din;
  logic        wr_en;
  logic        rd_en;
  logic        dout;
  logic        d_valid_out;
  logic [15:0] dcount_out;

  int checks = 0;
  int errors = 0;
  bit q[$];

  bit_serial_fifo #(.DEPTH_BYTES(DBYTES)) dut (
    .clk(clk), .srst(srst), .din(din), .wr_en(wr_en), .rd_en(rd_en),
    .dout(dout), .d_valid_out(d_valid_out), .dcount_out(dcount_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock with the given inputs; model updates from the pre-edge occupancy.
  task automatic step(input string tag, input bit we, input logic [7:0] d, input bit re);
    int  pre;
    bit  wacc, racc, eb;
    wr_en = we; din = d; rd_en = re; srst = 1'b1;
    @(posedge clk);
    pre  = q.size();
    wacc = we && (pre <= DBITS - 8);
    racc = re && (pre >= 1);
    eb   = 1'b0;
    if (racc) eb = q.pop_front();
    if (wacc) for (int i = 7; i >= 0; i--) q.push_back(d[i]);
    #1;
    check({tag, ".dout"},  16'(dout), 16'(eb));
    check({tag, ".valid"}, 16'(d_valid_out), 16'(racc));
    check({tag, ".count"}, dcount_out, 16'(q.size()));
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic do_reset(input string tag, input bit we, input bit re);
    srst = 1'b0; wr_en = we; rd_en = re; din = 8'hFF;
    @(posedge clk);
    q.delete();
    #1;
    check({tag, ".dout"},  16'(dout), 16'd0);
    check({tag, ".valid"}, 16'(d_valid_out), 16'd0);
    check({tag, ".count"}, dcount_out, 16'd0);
    srst = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
  endtask

  initial begin
    srst = 1'b0; din = 8'h00; wr_en = 1'b0; rd_en = 1'b0;
    @(posedge clk); #1;

    do_reset("rst0", 1'b1, 1'b1);

    // Empty read is ignored.
    step("empty_rd", 1'b0, 8'h00, 1'b1);

    // 0xA5 then eight reads: 1,0,1,0,0,1,0,1.
    step("a5_wr", 1'b1, 8'hA5, 1'b0);
    for (int i = 0; i < 8; i++) step("a5_rd", 1'b0, 8'h00, 1'b1);

    // Simultaneous write and read with one byte buffered: +7.
    step("ff_wr", 1'b1, 8'hFF, 1'b0);
    step("wr_rd", 1'b1, 8'h00, 1'b1);
    for (int i = 0; i < 15; i++) step("wr_rd_drain", 1'b0, 8'h00, 1'b1);

    // Read and write on an empty FIFO in the same cycle: no bypass.
    step("nobypass", 1'b1, 8'hC3, 1'b1);
    for (int i = 0; i < 8; i++) step("nobypass_drain", 1'b0, 8'h00, 1'b1);

    // Fill to capacity, overflow handling at the boundary.
    for (int i = 0; i < DBYTES; i++) step("fill", 1'b1, 8'($urandom), 1'b0);
    step("full_wr", 1'b1, 8'h5A, 1'b0);
    step("full_rd1", 1'b0, 8'h00, 1'b1);
    step("one_free_wr", 1'b1, 8'h5A, 1'b0);
    for (int i = 0; i < 7; i++) step("free_rd", 1'b0, 8'h00, 1'b1);
    step("byte_free_wr", 1'b1, 8'h96, 1'b0);

    // Drain past the pointer wrap.
    for (int i = 0; i < DBITS; i++) step("wrap_drain", 1'b0, 8'h00, 1'b1);

    // Random traffic across several wraps.
    for (int i = 0; i < 1500; i++)
      step("rand", ($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 1) == 1));

    // Mid-stream reset discards buffered bits.
    do_reset("rst1", 1'b0, 1'b0);
    step("ms_wr", 1'b1, 8'h3C, 1'b0);
    step("ms_wr", 1'b1, 8'h0F, 1'b0);
    step("ms_wr", 1'b1, 8'hF0, 1'b0);
    for (int i = 0; i < 5; i++) step("ms_rd", 1'b0, 8'h00, 1'b1);
    do_reset("rst2", 1'b1, 1'b1);
    step("post_wr", 1'b1, 8'h80, 1'b0);
    step("post_rd", 1'b0, 8'h00, 1'b1);
    check("post_rd.bit", 16'(dout), 16'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
